// File: rtl/mtsp_gmb_burst_reader.sv
// Burst reader: turns one (addr, len) command into a run of single-word GMB reads
// and streams the returned words out through a small credit-protected return FIFO.
module mtsp_gmb_burst_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  output logic                  GMB_CE,
  output logic                  GMB_WE,
  output logic [ADDR_WIDTH-1:0] GMB_ADDR,
  input  logic                  GMB_OE,
  input  logic [255:0]          GMB_DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic [255:0]          DOUT_DATA,
  output logic                  DOUT_LAST,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RUN_W = LEN_WIDTH + 1;
  localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RUN_W-1:0]      remaining_q, remaining_d;
  logic [RUN_W-1:0]      burst_len_q, burst_len_d;
  logic [RUN_W-1:0]      returned_q, returned_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;

  logic [255:0] fifo_data_q [FIFO_DEPTH];
  logic         fifo_last_q [FIFO_DEPTH];

  logic           accept, issue, push, pop, stray, push_last, head_last;
  logic [CNT_W:0] credit_sum;

  // Reads in flight plus words already buffered never exceed the FIFO depth,
  // so every return has a slot waiting regardless of consumer back-pressure.
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, count_q};
  assign accept     = (state_q == ST_IDLE) && CMD_VALID;
  assign issue      = (state_q == ST_ISSUE) && (credit_sum < DEPTH_SUM);
  assign push       = GMB_OE && (outstanding_q != '0);
  assign stray      = GMB_OE && (outstanding_q == '0);
  assign pop        = (count_q != '0) && DOUT_READY;
  assign push_last  = ((returned_q + RUN_W'(1)) == burst_len_q);
  assign head_last  = fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    burst_len_d   = burst_len_q;
    returned_d    = returned_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_ISSUE;
          addr_d      = CMD_ADDR;
          remaining_d = RUN_W'(CMD_LEN) + RUN_W'(1);
          burst_len_d = RUN_W'(CMD_LEN) + RUN_W'(1);
          returned_d  = '0;
          err_d       = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - RUN_W'(1);
          if (remaining_q == RUN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({issue, push})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      returned_d = returned_q + RUN_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A return with nothing outstanding is dropped; the flag wins over a same-cycle clear.
    if (stray) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      burst_len_q   <= '0;
      returned_q    <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      burst_len_q   <= burst_len_d;
      returned_q    <= returned_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= GMB_DOUT;
      fifo_last_q[wr_ptr_q] <= push_last;
    end
  end

  assign CMD_READY  = (state_q == ST_IDLE);
  assign BUSY       = (state_q != ST_IDLE);
  assign GMB_CE     = issue;
  assign GMB_WE     = 1'b0;
  assign GMB_ADDR   = addr_q;
  assign DOUT_VALID = (count_q != '0);
  assign DOUT_DATA  = DOUT_VALID ? fifo_data_q[rd_ptr_q] : '0;
  assign DOUT_LAST  = DOUT_VALID ? head_last : 1'b0;
  assign ERR        = err_q;

endmodule

// File: tb/tb_mtsp_gmb_burst_reader.sv
// Bench for mtsp_gmb_burst_reader: GMB memory model with random in-order latency,
// expected words derived from (addr, len), random consumer back-pressure.
module tb_mtsp_gmb_burst_reader;

  localparam int AW = 12;
  localparam int LW = 8;
  localparam int FD = 4;

  logic          CLK;
  logic          nRST;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR;
  logic [LW-1:0] CMD_LEN;
  logic          GMB_CE;
  logic          GMB_WE;
  logic [AW-1:0] GMB_ADDR;
  logic          GMB_OE;
  logic [255:0]  GMB_DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY;
  logic [255:0]  DOUT_DATA;
  logic          DOUT_LAST;
  logic          BUSY;
  logic          ERR;

  mtsp_gmb_burst_reader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .nRST(nRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .GMB_CE(GMB_CE), .GMB_WE(GMB_WE), .GMB_ADDR(GMB_ADDR), .GMB_OE(GMB_OE), .GMB_DOUT(GMB_DOUT),
    .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT_DATA(DOUT_DATA), .DOUT_LAST(DOUT_LAST),
    .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {logic [255:0] data; logic last;} word_t;
  typedef struct {int due; logic [255:0] data;} ret_t;

  int total = 0;
  int bad = 0;
  word_t         exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  ret_t          gmb_q[$];
  int cyc = 0;
  int last_due = 0;
  int ce_count = 0;
  int inflight = 0;
  int ready_mode = 1;
  bit stray_req = 1'b0;
  bit hold_valid = 1'b0;
  logic [255:0] hold_data;
  logic hold_last;
  bit chk_idle_next = 1'b0;

  function automatic logic [255:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = ({20'd0, a} + 32'd1) * 32'h9E37_79B9;
    return {h, ~h, h ^ 32'h5A5A_5A5A, {20'd0, a}, h, ~h, h + 32'd7, {20'd0, a}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // GMB memory model, issue checker and output scoreboard, all on the falling edge.
  always @(negedge CLK) begin
    if (!nRST) begin
      gmb_q.delete();
      GMB_OE = 1'b0;
      GMB_DOUT = '0;
      hold_valid = 1'b0;
      chk_idle_next = 1'b0;
      inflight = 0;
    end else begin
      cyc++;
      GMB_OE = 1'b0;
      GMB_DOUT = '0;
      if (stray_req) begin
        GMB_OE = 1'b1;
        GMB_DOUT = '1;
        stray_req = 1'b0;
      end else if (gmb_q.size() > 0 && gmb_q[0].due == cyc) begin
        GMB_OE = 1'b1;
        GMB_DOUT = gmb_q[0].data;
        void'(gmb_q.pop_front());
      end

      if (GMB_CE === 1'b1) begin
        ret_t r;
        int lat;
        ce_count++;
        inflight++;
        check("gmb_we", {255'd0, GMB_WE}, 256'd0);
        if (addr_exp_q.size() == 0) begin
          check("ce_unexpected", 256'd1, 256'd0);
        end else begin
          check("gmb_addr", {244'd0, GMB_ADDR}, {244'd0, addr_exp_q[0]});
          void'(addr_exp_q.pop_front());
        end
        check("credit", (inflight <= FD) ? 256'd1 : 256'd0, 256'd1);
        lat = int'($urandom_range(1, 3));
        r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.data = mem_word(GMB_ADDR);
        last_due = r.due;
        gmb_q.push_back(r);
      end

      case (ready_mode)
        0:       DOUT_READY = 1'b0;
        1:       DOUT_READY = 1'b1;
        default: DOUT_READY = 1'($urandom_range(0, 1));
      endcase

      if (hold_valid) begin
        check("hold_valid", {255'd0, DOUT_VALID}, 256'd1);
        check("hold_data", DOUT_DATA, hold_data);
        check("hold_last", {255'd0, DOUT_LAST}, {255'd0, hold_last});
      end
      if (chk_idle_next) begin
        check("idle_after_last", {254'd0, BUSY, CMD_READY}, 256'd1);
        chk_idle_next = 1'b0;
      end

      if (DOUT_VALID === 1'b1 && DOUT_READY) begin
        inflight--;
        if (exp_q.size() == 0) begin
          check("dout_unexpected", 256'd1, 256'd0);
        end else begin
          check("dout_data", DOUT_DATA, exp_q[0].data);
          check("dout_last", {255'd0, DOUT_LAST}, {255'd0, exp_q[0].last});
          if (exp_q[0].last) chk_idle_next = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      hold_valid = (DOUT_VALID === 1'b1) && !DOUT_READY;
      hold_data = DOUT_DATA;
      hold_last = DOUT_LAST;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i < 300; i++) begin
      if (CMD_READY === 1'b1) break;
      @(negedge CLK);
    end
    check("cmd_ready", {255'd0, CMD_READY}, 256'd1);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_ADDR = addr;
    CMD_LEN = LW'(len);
    for (int i = 0; i <= len; i++) begin
      word_t w;
      logic [AW-1:0] a;
      a = addr + AW'(i);
      w.data = mem_word(a);
      w.last = (i == len);
      exp_q.push_back(w);
      addr_exp_q.push_back(a);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && BUSY === 1'b0) break;
    end
    check("words_left", 256'(exp_q.size()), 256'd0);
    check("addrs_left", 256'(addr_exp_q.size()), 256'd0);
    check("busy_done", {255'd0, BUSY}, 256'd0);
    check("ready_done", {255'd0, CMD_READY}, 256'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0;
    nRST = 1'b0;
    CMD_VALID = 1'b0;
    CMD_ADDR = '0;
    CMD_LEN = '0;
    DOUT_READY = 1'b1;
    GMB_OE = 1'b0;
    GMB_DOUT = '0;
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", {255'd0, CMD_READY}, 256'd1);
    check("rst_outputs", {249'd0, GMB_CE, GMB_WE, DOUT_VALID, DOUT_LAST, BUSY, ERR, 1'b0}, 256'd0);
    check("rst_addr", {244'd0, GMB_ADDR}, 256'd0);
    check("rst_data", DOUT_DATA, 256'd0);
    @(posedge CLK);
    #2 nRST = 1'b1;

    // single word
    ready_mode = 1;
    ce0 = ce_count;
    send_cmd(12'h010, 0);
    wait_done(100);
    check("single_ce", 256'(ce_count - ce0), 256'd1);

    // address wrap
    send_cmd(12'hFFE, 7);
    wait_done(200);

    // consumer stalled: issue must stop at the FIFO depth
    ready_mode = 0;
    ce0 = ce_count;
    send_cmd(12'(($urandom_range(0, 4095))), 15);
    repeat (20) @(negedge CLK);
    check("stall_ce", 256'(ce_count - ce0), 256'(FD));
    check("stall_valid", {255'd0, DOUT_VALID}, 256'd1);
    ready_mode = 1;
    wait_done(300);
    check("stall_total_ce", 256'(ce_count - ce0), 256'd16);

    // long burst with random back-pressure
    ready_mode = 2;
    ce0 = ce_count;
    send_cmd(12'($urandom_range(0, 4095)), 255);
    wait_done(3000);
    check("long_ce", 256'(ce_count - ce0), 256'd256);

    for (int n = 0; n < 6; n++) begin
      ready_mode = int'($urandom_range(1, 2));
      send_cmd(12'($urandom_range(0, 4095)), int'($urandom_range(0, 40)));
      wait_done(800);
    end

    // stray return in IDLE
    ready_mode = 1;
    stray_req = 1'b1;
    repeat (3) @(negedge CLK);
    check("stray_err", {255'd0, ERR}, 256'd1);
    check("stray_valid", {255'd0, DOUT_VALID}, 256'd0);
    send_cmd(12'($urandom_range(0, 4095)), 2);
    check("err_cleared", {255'd0, ERR}, 256'd0);
    wait_done(100);

    // reset in the middle of a burst
    ready_mode = 1;
    ce0 = ce_count;
    send_cmd(12'h100, 15);
    for (int i = 0; i < 100; i++) begin
      if (ce_count - ce0 >= 5) break;
      @(negedge CLK);
    end
    check("reset_ce_seen", (ce_count - ce0 >= 5) ? 256'd1 : 256'd0, 256'd1);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {255'd0, CMD_READY}, 256'd1);
    check("mid_rst_outputs", {249'd0, GMB_CE, GMB_WE, DOUT_VALID, DOUT_LAST, BUSY, ERR, 1'b0}, 256'd0);
    check("mid_rst_addr", {244'd0, GMB_ADDR}, 256'd0);
    check("mid_rst_data", DOUT_DATA, 256'd0);
    exp_q.delete();
    addr_exp_q.delete();
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_ready", {255'd0, CMD_READY}, 256'd1);
    check("post_rst_valid", {255'd0, DOUT_VALID}, 256'd0);
    check("post_rst_busy", {255'd0, BUSY}, 256'd0);

    // recovery burst
    ready_mode = 2;
    send_cmd(12'($urandom_range(0, 4095)), 3);
    wait_done(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtsp_gmb_burst_reader.md
MTSP_GMB_BURST_READER -- requirements
Module: mtsp_gmb_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, GMB word address width (one word = 256 bits).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, command length field width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, return buffer depth in words (power of 2, >=2).
REQ-004 SHALL have port CLK  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-006 SHALL have port CMD_VALID  in  1  burst command request.
REQ-007 SHALL have port CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY.
REQ-008 SHALL have port CMD_ADDR  in  ADDR_WIDTH  start word address.
REQ-009 SHALL have port CMD_LEN  in  LEN_WIDTH  word count minus 1.
REQ-010 SHALL have port GMB_CE  out  1  GMB chip enable, one read per cycle high.
REQ-011 SHALL have port GMB_WE  out  1  GMB write enable, tied 0.
REQ-012 SHALL have port GMB_ADDR  out  ADDR_WIDTH  GMB read address.
REQ-013 SHALL have port GMB_OE  in  1  GMB read data valid, in-order, latency >=1 cycle.
REQ-014 SHALL have port GMB_DOUT  in  256  GMB read data.
REQ-015 SHALL have port DOUT_VALID  out  1  output word available.
REQ-016 SHALL have port DOUT_READY  in  1  consumer accepts word.
REQ-017 SHALL have port DOUT_DATA  out  256  output word.
REQ-018 SHALL have port DOUT_LAST  out  1  marks final word of burst.
REQ-019 SHALL have port BUSY  out  1  high whenever state != IDLE.
REQ-020 SHALL have port ERR  out  1  sticky: GMB_OE received with zero outstanding reads.

Function
REQ-021 SHALL implement FSM IDLE, ISSUE, DRAIN; CMD_READY=1 only in IDLE.
REQ-022 IDLE: on CMD_VALID&CMD_READY SHALL latch addr, remaining=CMD_LEN+1 (LEN_WIDTH+1 bits), clear ERR, go ISSUE next cycle.
REQ-023 ISSUE: SHALL drive GMB_CE=1 in a cycle iff outstanding+fifo_count < FIFO_DEPTH (credit rule), GMB_ADDR=current addr.
REQ-024 Each issued read SHALL increment addr modulo 2^ADDR_WIDTH (wrap all-ones -> 0) and decrement remaining.
REQ-025 After issuing final read (remaining 1->0) SHALL go DRAIN; no GMB_CE in IDLE or DRAIN.
REQ-026 outstanding SHALL increment on issue, decrement on GMB_OE; simultaneous events leave it unchanged.
REQ-027 Every GMB_OE with outstanding>0 (or issue in same cycle not counted) SHALL push GMB_DOUT into FIFO; last-return tag = returned count equals burst length.
REQ-028 FIFO SHALL not bypass: word pushed in cycle t visible on DOUT_* no earlier than t+1.
REQ-029 DOUT_VALID SHALL equal FIFO non-empty; pop on DOUT_VALID&DOUT_READY; push and pop same cycle keep count.
REQ-030 DOUT_DATA/DOUT_LAST SHALL hold stable while DOUT_VALID&!DOUT_READY.
REQ-031 Credit rule SHALL guarantee FIFO never overflows for any DOUT_READY pattern.
REQ-032 DRAIN SHALL return to IDLE in the cycle after the DOUT_LAST word is popped; new command acceptable that cycle.
REQ-033 GMB_OE with outstanding=0 SHALL be dropped (no push) and set ERR=1.
REQ-034 Output words SHALL appear in issue order; throughput 1 word/cycle when DOUT_READY=1 and latency < FIFO_DEPTH.

Reset
REQ-035 nRST low SHALL immediately force: state IDLE, CMD_READY=1, GMB_CE=0, GMB_WE=0, GMB_ADDR=0, DOUT_VALID=0, DOUT_DATA=0, DOUT_LAST=0, BUSY=0, ERR=0, counters and FIFO empty.
REQ-036 Reset mid-burst SHALL discard the burst; GMB shares nRST so no late returns arrive.

Verification
REQ-037 CMD_ADDR=0x010, LEN=0, DOUT_READY=1 -> one GMB_CE at addr 0x010, WE=0; one output word = mem[0x010], LAST=1; BUSY drops, CMD_READY=1.
REQ-038 CMD_ADDR=0xFFE, LEN=7 -> GMB_ADDR 0xFFE,0xFFF,0x000..0x005 in order; 8 outputs, LAST only on 8th.
REQ-039 CMD_LEN=15, DOUT_READY=0 -> exactly 4 GMB_CE pulses then stall, outstanding+count <=4 always; release READY -> 16 words in order, no loss.
REQ-040 CMD_LEN=255 with random DOUT_READY -> 256 words, addresses contiguous, LAST on word 256 only.
REQ-041 nRST low after 5 issues of LEN=15 -> all outputs at REQ-035 values at once; after release CMD_READY=1, no DOUT_VALID.
REQ-042 GMB_OE pulse in IDLE -> ERR=1, DOUT_VALID stays 0; next command accept clears ERR.
